// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared arbiter types and the round-robin pointer wrap helper.
// Rev     : 1.0  initial release
// ============================================================================
package arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   localparam int unsigned ARB_PTR_MAX_W = 16;

   // Increment modulo 2**ctrl; callers cast the result to their own pointer width.
   function automatic logic [ARB_PTR_MAX_W-1:0] rr_next(
      input logic [ARB_PTR_MAX_W-1:0] ptr,
      input int unsigned              ctrl
   );
      logic [ARB_PTR_MAX_W-1:0] mask;
      mask = (ARB_PTR_MAX_W'(1) << ctrl) - ARB_PTR_MAX_W'(1);
      return (ptr + ARB_PTR_MAX_W'(1)) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb_mux_if
// Brief   : N request channels in, one arbitrated channel out (valid/ready).
// Rev     : 1.0  initial release
// ============================================================================
interface rr_arb_mux_if #(
   parameter int unsigned CTRL       = 2,
   parameter int unsigned DATA_WIDTH = 1
);
   localparam int unsigned N = 2**CTRL;

   logic [N-1:0]          in_valid;
   logic [DATA_WIDTH-1:0] in_data [N];
   logic [N-1:0]          in_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CTRL-1:0]       out_sel;
   logic                  out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb_mux_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : First valid request at or after ptr, wrapping modulo N.
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int unsigned CTRL = 2
) (
   input  logic [2**CTRL-1:0] valid_i,
   input  logic [CTRL-1:0]    ptr_i,
   output logic               any_valid_o,
   output logic [CTRL-1:0]    idx_o
);
   localparam int unsigned N = 2**CTRL;

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      logic [CTRL-1:0] cand;
      any_valid_o = |valid_i;
      idx_o       = '0;
      cand        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ptr_i + CTRL'(k);
         if (valid_i[cand]) begin
            idx_o = cand;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb_mux
// Brief   : Round-robin N:1 valid/ready mux with grant lock while stalled.
//           Define RR_ARB_MUX_OUT_REG_EN for a 1-entry registered output stage.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arb_mux
   import arb_pkg::*;
#(
   parameter int unsigned CTRL       = 2,
   parameter int unsigned DATA_WIDTH = 1
) (
   input  logic         clk,
   input  logic         reset,
   rr_arb_mux_if.slave  bus
);
   arb_state_e            state_q, state_d, state_eff;
   logic [CTRL-1:0]       ptr_q, ptr_d, ptr_eff;
   logic [CTRL-1:0]       gnt_q, gnt_d, gnt;
   logic [CTRL-1:0]       pick_idx;
   logic                  pick_any;
   logic                  arb_valid, arb_ready, arb_hs;
   logic [DATA_WIDTH-1:0] arb_data;
   logic [CTRL-1:0]       arb_sel;

   // While reset is asserted the outputs already behave as IDLE with ptr=0.
   assign state_eff = reset ? ARB_IDLE : state_q;
   assign ptr_eff   = reset ? '0 : ptr_q;

   rr_pick #(.CTRL(CTRL)) u_pick (
      .valid_i     (bus.in_valid),
      .ptr_i       (ptr_eff),
      .any_valid_o (pick_any),
      .idx_o       (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      state_d = state_eff;
      ptr_d   = ptr_eff;
      gnt_d   = gnt;
      case (state_eff)
         ARB_IDLE: if (arb_valid && !arb_ready) state_d = ARB_HOLD;
         ARB_HOLD: if (arb_hs)                  state_d = ARB_IDLE;
         default:                               state_d = ARB_IDLE;
      endcase
      if (arb_hs) begin
         ptr_d = CTRL'(rr_next(ARB_PTR_MAX_W'(gnt), CTRL));
      end
   end

   always_comb begin
      gnt          = (state_eff == ARB_HOLD) ? gnt_q : pick_idx;
      arb_valid    = pick_any && bus.in_valid[gnt];
      arb_data     = arb_valid ? bus.in_data[gnt] : '0;
      arb_sel      = arb_valid ? gnt : '0;
      arb_hs       = arb_valid && arb_ready;
      bus.in_ready = '0;
      bus.in_ready[gnt] = arb_ready;
   end

`ifdef RR_ARB_MUX_OUT_REG_EN
   logic                  full_q;
   logic [DATA_WIDTH-1:0] odata_q;
   logic [CTRL-1:0]       osel_q;

   // Skid-free single entry: refills in the same cycle it drains.
   assign arb_ready = !full_q || bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q  <= 1'b0;
         odata_q <= '0;
         osel_q  <= '0;
      end else if (arb_hs) begin
         full_q  <= 1'b1;
         odata_q <= arb_data;
         osel_q  <= arb_sel;
      end else if (bus.out_ready) begin
         full_q  <= 1'b0;
      end
   end

   assign bus.out_valid = full_q;
   assign bus.out_data  = odata_q;
   assign bus.out_sel   = osel_q;
`else
   assign arb_ready     = bus.out_ready;
   assign bus.out_valid = arb_valid;
   assign bus.out_data  = arb_data;
   assign bus.out_sel   = arb_sel;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arb_mux
// Brief   : Directed and randomized self-checking bench for rr_arb_mux.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;
   localparam int unsigned DW = 8;
`ifdef RR_ARB_MUX_OUT_REG_EN
   localparam bit REG = 1'b1;
`else
   localparam bit REG = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   rr_arb_mux_if #(.CTRL(2), .DATA_WIDTH(DW)) bus4 ();
   rr_arb_mux_if #(.CTRL(1), .DATA_WIDTH(DW)) bus2 ();

   rr_arb_mux #(.CTRL(2), .DATA_WIDTH(DW)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
   rr_arb_mux #(.CTRL(1), .DATA_WIDTH(DW)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model of the 4-input instance ----------------
   int        m_ptr, m_held;
   bit        m_lock, m_full;
   logic [7:0] m_data;
   int        m_sel;

   function automatic int m_gnt();
      int i;
      if (m_lock) return m_held;
      for (int k = 0; k < 4; k++) begin
         i = (m_ptr + k) % 4;
         if (bus4.in_valid[i]) return i;
      end
      return 0;
   endfunction

   function automatic bit m_ar();
      return REG ? (!m_full || bus4.out_ready) : bus4.out_ready;
   endfunction

   always @(posedge clk) begin
      int g;
      bit av, ar;
      g  = m_gnt();
      av = bus4.in_valid[g];
      ar = m_ar();
      if (reset) begin
         m_ptr <= 0; m_lock <= 1'b0; m_held <= 0;
         m_full <= 1'b0; m_data <= 8'h00; m_sel <= 0;
      end else begin
         if (av && ar) begin
            m_full <= 1'b1; m_data <= bus4.in_data[g]; m_sel <= g;
            m_ptr  <= (g + 1) % 4; m_lock <= 1'b0;
         end else begin
            if (bus4.out_ready) m_full <= 1'b0;
            if (av) begin m_lock <= 1'b1; m_held <= g; end
         end
      end
   end

   always @(negedge clk) begin
      int g;
      bit av, ev;
      logic [7:0] ed;
      int es;
      if (!reset) begin
         g  = m_gnt();
         av = bus4.in_valid[g];
         ev = REG ? m_full : av;
         ed = REG ? m_data : (av ? bus4.in_data[g] : 8'h00);
         es = REG ? m_sel : (av ? g : 0);
         chk("in_ready", 32'(bus4.in_ready), m_ar() ? (32'd1 << g) : 32'd0);
         chk("out_valid", 32'(bus4.out_valid), 32'(ev));
         if (ev || !REG) begin
            chk("out_sel", 32'(bus4.out_sel), 32'(es));
            chk("out_data", 32'(bus4.out_data), 32'(ed));
         end
      end
   end

   // Output beats of the 4-input instance, in emission order.
   logic [7:0] log4[$];
   always @(negedge clk) begin
      if (!reset && bus4.out_valid && bus4.out_ready) log4.push_back(bus4.out_data);
   end

   function automatic logic [31:0] log_at(input int idx);
      return (idx < log4.size()) ? 32'(log4[idx]) : 32'hDEAD;
   endfunction

   // ---------------- scoreboard of the 2-input instance ----------------
   bit sb_en = 1'b0;
   int issued[2];
   int rcvd[2];
   int waitc[2];

   always @(negedge clk) begin
      int s;
      logic [1:0] a;
      if (!reset && sb_en) begin
         a = bus2.in_valid & bus2.in_ready;
         chk("t6_onehot", 32'($countones(bus2.in_ready) <= 1), 32'd1);
         if (bus2.out_valid && bus2.out_ready) begin
            s = int'(bus2.out_sel);
            chk("t6_src", 32'(bus2.out_data[7]), 32'(s));
            chk("t6_seq", 32'(bus2.out_data[6:0]), 32'(rcvd[s] % 128));
            rcvd[s]++;
         end
         for (int i = 0; i < 2; i++) begin
            if (a[i]) begin
               chk("t6_wait", 32'(waitc[i] <= 1), 32'd1);
               waitc[i] = 0;
            end else if (bus2.in_valid[i] && a != 2'b00) begin
               waitc[i]++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [3:0] acc4;
   logic [1:0] acc2;

   task automatic sample();
      @(negedge clk);
      acc4 = bus4.in_valid & bus4.in_ready;
      acc2 = bus2.in_valid & bus2.in_ready;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      bus4.in_valid = bus4.in_valid & ~acc4;
      bus2.in_valid = bus2.in_valid & ~acc2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus4.in_valid = '0; bus4.out_ready = 1'b0;
      bus2.in_valid = '0; bus2.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      log4.delete();
   endtask

   initial begin
      bus4.in_valid = '0; bus4.out_ready = 1'b0;
      bus2.in_valid = '0; bus2.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) bus4.in_data[i] = 8'h00;
      for (int i = 0; i < 2; i++) bus2.in_data[i] = 8'h00;
      for (int i = 0; i < 2; i++) begin issued[i] = 0; rcvd[i] = 0; waitc[i] = 0; end

      // Reset state
      do_reset();
      sample();
      chk("rst_valid", 32'(bus4.out_valid), 32'd0);
      chk("rst_sel", 32'(bus4.out_sel), 32'd0);
      chk("rst_data", 32'(bus4.out_data), 32'd0);
      chk("rst_ready", 32'(bus4.in_ready), 32'd0);
      advance();

      // 1: all four valid, continuous acceptance rotates A0..A3 then wraps
      do_reset();
      for (int i = 0; i < 4; i++) bus4.in_data[i] = 8'hA0 + 8'(i);
      bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
      repeat (6) begin sample(); advance(); bus4.in_valid = 4'hF; end
      bus4.in_valid = 4'h0;
      chk("t1_count", 32'(log4.size() >= 5), 32'd1);
      chk("t1_b0", log_at(0), 32'hA0);
      chk("t1_b1", log_at(1), 32'hA1);
      chk("t1_b2", log_at(2), 32'hA2);
      chk("t1_b3", log_at(3), 32'hA3);
      chk("t1_b4", log_at(4), 32'hA0);

      // 2: lone valid input granted regardless of ptr
      do_reset();
      bus4.in_data[2] = 8'h5C; bus4.in_valid = 4'b0100; bus4.out_ready = 1'b1;
      sample();
`ifndef RR_ARB_MUX_OUT_REG_EN
      chk("t2_valid", 32'(bus4.out_valid), 32'd1);
      chk("t2_sel", 32'(bus4.out_sel), 32'd2);
      chk("t2_data", 32'(bus4.out_data), 32'h5C);
`else
      chk("t2_lat0", 32'(bus4.out_valid), 32'd0);
`endif
      advance();
`ifdef RR_ARB_MUX_OUT_REG_EN
      sample();
      chk("t2_valid", 32'(bus4.out_valid), 32'd1);
      chk("t2_sel", 32'(bus4.out_sel), 32'd2);
      chk("t2_data", 32'(bus4.out_data), 32'h5C);
      advance();
`endif

      // 3: stall on input 3, higher-priority input 0 must not steal the grant
      do_reset();
      bus4.in_data[3] = 8'h33; bus4.in_data[0] = 8'h30;
      bus4.in_valid = 4'b1000; bus4.out_ready = 1'b0;
      sample();
`ifndef RR_ARB_MUX_OUT_REG_EN
      chk("t3_sel0", 32'(bus4.out_sel), 32'd3);
`endif
      advance();
      bus4.in_valid = bus4.in_valid | 4'b0001;
      repeat (3) begin
         sample();
         chk("t3_hold_sel", 32'(bus4.out_sel), 32'd3);
         chk("t3_hold_valid", 32'(bus4.out_valid), 32'd1);
         advance();
      end
      bus4.out_ready = 1'b1;
      sample();
      chk("t3_acc_sel", 32'(bus4.out_sel), 32'd3);
      advance();
      sample();
      chk("t3_next_sel", 32'(bus4.out_sel), 32'd0);
      chk("t3_next_data", 32'(bus4.out_data), 32'h30);
      advance();

      // 4: accept 2 then 3 (ptr wraps to 0); then 0 beats a re-raised 3
      do_reset();
      bus4.in_data[2] = 8'h42; bus4.in_data[3] = 8'h43;
      bus4.in_valid = 4'b1100; bus4.out_ready = 1'b1;
      sample(); advance();
      sample(); advance();
      bus4.in_data[0] = 8'h40; bus4.in_data[3] = 8'h53;
      bus4.in_valid = 4'b1001;
      repeat (4) begin sample(); advance(); end
      chk("t4_count", 32'(log4.size()), 32'd4);
      chk("t4_b0", log_at(0), 32'h42);
      chk("t4_b1", log_at(1), 32'h43);
      chk("t4_b2", log_at(2), 32'h40);
      chk("t4_b3", log_at(3), 32'h53);

      // 5: reset while input 1 is pending; its beat is dropped
      do_reset();
      bus4.in_data[1] = 8'h11; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b0;
      sample(); advance();
      sample(); advance();
      do_reset();
      bus4.in_data[0] = 8'h20; bus4.in_data[1] = 8'h21;
      bus4.in_valid = 4'b0011; bus4.out_ready = 1'b1;
      repeat (4) begin sample(); advance(); end
      chk("t5_count", 32'(log4.size()), 32'd2);
      chk("t5_b0", log_at(0), 32'h20);
      chk("t5_b1", log_at(1), 32'h21);

      // 6: two inputs, random valid/ready, ordering and fairness scoreboard
      do_reset();
      sb_en = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!bus2.in_valid[i] && ($urandom_range(0, 1) == 1)) begin
               bus2.in_data[i]  = {1'(i), 7'(issued[i])};
               bus2.in_valid[i] = 1'b1;
               issued[i]++;
            end
         end
         bus2.out_ready = ($urandom_range(0, 3) != 0);
         sample(); advance();
      end
      bus2.out_ready = 1'b1;
      repeat (8) begin sample(); advance(); end
      chk("t6_loss0", 32'(rcvd[0]), 32'(issued[0]));
      chk("t6_loss1", 32'(rcvd[1]), 32'(issued[1]));
      chk("t6_activity", 32'(rcvd[0] > 100 && rcvd[1] > 100), 32'd1);
      sb_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
